// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: byte type, word width and FSM states.
package mem_pkg;
  typedef logic [7:0] byte_t;
  localparam int WORD_BYTES = 4;
  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_e;
endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the core data port (master) and the memory responder (slave).
interface data_mem_responder_if #(parameter int XLEN = 32);
  import mem_pkg::*;
  logic                         req_valid;
  logic                         req_ready;
  logic                         req_write;
  logic [XLEN-1:0]              req_addr;
  byte_t [WORD_BYTES-1:0]       mem_data_in;
  logic                         resp_valid;
  byte_t [WORD_BYTES-1:0]       mem_data_out;
  logic                         resp_err;

  modport master (
    output req_valid, req_write, req_addr, mem_data_in,
    input  req_ready, resp_valid, mem_data_out, resp_err
  );
  modport slave (
    input  req_valid, req_write, req_addr, mem_data_in,
    output req_ready, resp_valid, mem_data_out, resp_err
  );
endinterface

// File: rtl/mem_latency_counter.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
module mem_latency_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                   count <= '0;
    else if (load)                count <= load_val;
    else if (dec && count != '0)  count <= count - 1'b1;
  end

  assign zero = (count == '0);
endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency word memory responder with byte-lane storage and wrap-around indexing.
// Optional macro MEM_ALIGN_CHECK_EN rejects misaligned accesses with resp_err.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 4
) (
  input  logic                 clk,
  input  logic                 rst_b,
  data_mem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_BYTES);
  typedef logic [AW-1:0] idx_t;

  mem_state_e             state;
  logic                   write_q;
  idx_t                   addr_q;
  byte_t [WORD_BYTES-1:0] wdata_q;
  byte_t [WORD_BYTES-1:0] rdata;
  byte_t [WORD_BYTES-1:0] dout_q;
  logic                   resp_q;
  logic                   err_q;
  logic                   mis;
  logic                   zero;
  logic                   access;
  logic [3:0]             unused_cnt;
  logic                   unused_addr_hi;

  byte_t mem [DEPTH_BYTES];
  idx_t  idx [WORD_BYTES];

  // Only the low AW address bits select storage; the rest alias.
  assign unused_addr_hi = ^bus.req_addr[XLEN-1:AW];
  assign access         = (state == MEM_BUSY) && zero;

`ifdef MEM_ALIGN_CHECK_EN
  assign mis = (addr_q[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  mem_latency_counter #(.W(4)) u_cnt (
    .clk      (clk),
    .rst_b    (rst_b),
    .load     ((state == MEM_IDLE) && bus.req_valid),
    .load_val (4'(LATENCY - 1)),
    .dec      (state == MEM_BUSY),
    .count    (unused_cnt),
    .zero     (zero)
  );

  // Lane i maps to byte addr+i, wrapping modulo the array size.
  always_comb begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      idx[i]   = addr_q + idx_t'(i);
      rdata[i] = mem[idx[i]];
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= MEM_IDLE;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      resp_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        MEM_IDLE: if (bus.req_valid) begin
          write_q <= bus.req_write;
          addr_q  <= bus.req_addr[AW-1:0];
          wdata_q <= bus.mem_data_in;
          state   <= MEM_BUSY;
        end
        MEM_BUSY: if (zero) begin
          state  <= MEM_RESP;
          resp_q <= 1'b1;
          err_q  <= mis;
          if (mis)           dout_q <= '0;
          else if (!write_q) dout_q <= rdata;
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

  // Storage is deliberately not reset; reset only ever drops a pending access.
  always_ff @(posedge clk) begin
    if (access && write_q && !mis) begin
      for (int i = 0; i < WORD_BYTES; i++) mem[idx[i]] <= wdata_q[i];
    end
  end

  assign bus.req_ready    = (state == MEM_IDLE);
  assign bus.resp_valid   = resp_q;
  assign bus.mem_data_out = dout_q;
  assign bus.resp_err     = err_q;
endmodule
